multi_cycle_ctrl: RTL and testbench

Parametrised multi-cycle sequencer that replaces the fixed 4-state fetch/execute/memory controller in the single-issue core. It drives the `imem_ift` and `dmem_ift` `Mem_ift` handshakes and latches the fetched instruction. It produces the `stall` and `commit` strobes that gate register writeback and cosim. Over the previous generation it adds:

- parametrised data width and instruction-slot selection;
- a per-wait timeout with a sticky fault state;
- a debug halt;
- retired-instruction and cycle counters.

---
 rtl/multi_cycle_ctrl_pkg.sv | 23 ++
 rtl/mem_ift.sv | 40 ++++
 rtl/multi_cycle_ctrl_wait_timer.sv | 35 +++
 rtl/multi_cycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared types for the multi-cycle sequencer.
// State and fault-cause encodings plus the reset instruction.
package CorePack;

  typedef enum logic [2:0] {
    IF_REQ,
    IF_RESP,
    EXE,
    MEM_RESP,
    HALT,
    FAULT
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FC_NONE,
    FC_FETCH_TO,
    FC_DATA_TO,
    FC_LDST
  } fault_cause_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/mem_ift.sv
// Valid/ready memory handshake: read request/reply and
// write request/reply channels.
interface Mem_ift #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wmask;
  } w_req_t;

  logic                  r_request_valid;
  logic                  r_request_ready;
  logic [ADDR_WIDTH-1:0] r_request_bits;
  logic                  r_reply_valid;
  logic                  r_reply_ready;
  logic [DATA_WIDTH-1:0] r_reply_bits;
  logic                  w_request_valid;
  logic                  w_request_ready;
  w_req_t                w_request_bits;
  logic                  w_reply_valid;
  logic                  w_reply_ready;

  modport Master (
    output r_request_valid, r_request_bits, r_reply_ready,
    output w_request_valid, w_request_bits, w_reply_ready,
    input  r_request_ready, r_reply_valid, r_reply_bits,
    input  w_request_ready, w_reply_valid
  );

  modport Slave (
    input  r_request_valid, r_request_bits, r_reply_ready,
    input  w_request_valid, w_request_bits, w_reply_ready,
    output r_request_ready, r_reply_valid, r_reply_bits,
    output w_request_ready, w_reply_valid
  );

endinterface

// File: rtl/multi_cycle_ctrl_wait_timer.sv
// Per-state wait counter; expired flags the last allowed
// cycle of a wait. TIMEOUT of 0 never expires.
module wait_timer #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle fetch/execute/memory sequencer with timeout,
// debug halt and performance counters.
module multi_cycle_ctrl
  import CorePack::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TIMEOUT    = 256,
  parameter int unsigned CNT_WIDTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  Mem_ift.Master                  imem_ift,
  Mem_ift.Master                  dmem_ift,
  input  logic [ADDR_WIDTH-1:0]   pc,
  input  logic                    re_mem,
  input  logic                    we_mem,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  input  logic                    halt_req,
  output logic [31:0]             inst,
  output logic                    stall,
  output logic                    commit,
  output logic                    halted,
  output logic                    fault,
  output logic [1:0]              fault_cause,
  output logic [CNT_WIDTH-1:0]    cycle_cnt,
  output logic [CNT_WIDTH-1:0]    instret_cnt
);

  localparam int unsigned SLOTS = DATA_WIDTH / 32;

  ctrl_state_e          state_q, state_d;
  fault_cause_e         cause_q, cause_d;
  logic [31:0]          inst_q, inst_d;
  logic                 is_store_q, is_store_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d, ret_q, ret_d;
  logic [31:0]          slot;
  logic                 ld_only, st_only, ld_st;
  logic                 fire, waiting, expired, commit_w;
  logic                 unused_in;

  assign ld_only = re_mem & ~we_mem;
  assign st_only = we_mem & ~re_mem;
  assign ld_st   = re_mem & we_mem;

  if (SLOTS == 1) begin : g_one_slot
    assign slot = imem_ift.r_reply_bits[31:0];
  end else begin : g_slots
    localparam int unsigned HI = $clog2(DATA_WIDTH / 8) - 1;
    logic [HI-2:0] idx;
    assign idx  = pc[HI:2];
    assign slot = imem_ift.r_reply_bits[{idx, 5'b0} +: 32];
  end

  always_comb begin
    fire = 1'b0;
    unique case (state_q)
      IF_REQ:   fire = imem_ift.r_request_ready;
      IF_RESP:  fire = imem_ift.r_reply_valid;
      EXE:      fire = (ld_only & dmem_ift.r_request_ready)
                     | (st_only & dmem_ift.w_request_ready);
      MEM_RESP: fire = is_store_q ? dmem_ift.w_reply_valid
                                  : dmem_ift.r_reply_valid;
      default:  fire = 1'b0;
    endcase
  end

  assign waiting = (state_q == IF_REQ) || (state_q == IF_RESP)
                || (state_q == MEM_RESP)
                || (state_q == EXE && (re_mem ^ we_mem));

  assign commit_w = rst &&
    ((state_q == EXE && !re_mem && !we_mem) ||
     (state_q == MEM_RESP && fire));

  always_comb begin
    imem_ift.r_request_valid = 1'b0;
    imem_ift.r_reply_ready   = 1'b0;
    imem_ift.w_request_valid = 1'b0;
    imem_ift.w_reply_ready   = 1'b0;
    imem_ift.r_request_bits  = pc;
    imem_ift.w_request_bits  = '0;
    dmem_ift.r_request_valid = 1'b0;
    dmem_ift.r_reply_ready   = 1'b0;
    dmem_ift.w_request_valid = 1'b0;
    dmem_ift.w_reply_ready   = 1'b0;
    dmem_ift.r_request_bits  = mem_addr;
    dmem_ift.w_request_bits  = {mem_addr, wdata, wmask};
    if (rst) begin
      unique case (state_q)
        IF_REQ:  imem_ift.r_request_valid = 1'b1;
        IF_RESP: imem_ift.r_reply_ready = 1'b1;
        EXE: begin
          dmem_ift.r_request_valid = ld_only;
          dmem_ift.w_request_valid = st_only;
        end
        MEM_RESP: begin
          dmem_ift.w_reply_ready = is_store_q;
          dmem_ift.r_reply_ready = ~is_store_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    inst_d     = inst_q;
    is_store_d = is_store_q;
    cyc_d      = cyc_q;
    ret_d      = commit_w ? ret_q + 1'b1 : ret_q;
    if (state_q != HALT && state_q != FAULT)
      cyc_d = cyc_q + 1'b1;
    unique case (state_q)
      IF_REQ:  if (fire) state_d = IF_RESP;
      IF_RESP: if (fire) begin
        inst_d  = slot;
        state_d = EXE;
      end
      EXE: begin
        if (ld_st) begin
          state_d = FAULT;
          cause_d = FC_LDST;
        end else if (commit_w) begin
          state_d = halt_req ? HALT : IF_REQ;
        end else if (fire) begin
          state_d    = MEM_RESP;
          is_store_d = we_mem;
        end
      end
      MEM_RESP: if (fire) state_d = halt_req ? HALT : IF_REQ;
      HALT:     if (!halt_req) state_d = IF_REQ;
      default:  ;
    endcase
    // A fire in the expiring cycle wins over the timeout.
    if (waiting && !fire && expired) begin
      state_d = FAULT;
      cause_d = (state_q == IF_REQ || state_q == IF_RESP)
              ? FC_FETCH_TO : FC_DATA_TO;
    end
  end

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .en      (waiting && !fire),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IF_REQ;
      cause_q    <= FC_NONE;
      inst_q     <= NOP;
      is_store_q <= 1'b0;
      cyc_q      <= '0;
      ret_q      <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      inst_q     <= inst_d;
      is_store_q <= is_store_d;
      cyc_q      <= cyc_d;
      ret_q      <= ret_d;
    end
  end

  assign inst        = inst_q;
  assign commit      = commit_w;
  assign stall       = ~commit_w;
  assign halted      = (state_q == HALT);
  assign fault       = (state_q == FAULT);
  assign fault_cause = cause_q;
  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;

  assign unused_in = ^{imem_ift.w_request_ready, imem_ift.w_reply_valid,
                       dmem_ift.r_reply_bits};

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl with a per-cycle
// transaction-level model of commit, halt, fault and counters.
module tb_multi_cycle_ctrl;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int CW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] pc, mem_addr;
  logic          re_mem, we_mem, halt_req;
  logic [DW-1:0] wdata;
  logic [7:0]    wmask;
  logic [31:0]   inst;
  logic          stall, commit, halted, fault;
  logic [1:0]    fault_cause;
  logic [CW-1:0] cycle_cnt, instret_cnt;

  Mem_ift #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) imem ();
  Mem_ift #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dmem ();

  multi_cycle_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .imem_ift(imem), .dmem_ift(dmem),
    .pc(pc), .re_mem(re_mem), .we_mem(we_mem),
    .mem_addr(mem_addr), .wdata(wdata), .wmask(wmask),
    .halt_req(halt_req), .inst(inst), .stall(stall),
    .commit(commit), .halted(halted), .fault(fault),
    .fault_cause(fault_cause), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  logic       exp_commit, exp_halted, exp_fault;
  logic [1:0] exp_cause;
  logic [63:0] m_cyc = 0;
  logic [63:0] m_ret = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // Cycles count while neither halted nor faulted; retires
  // count commits; reset clears both at the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("commit", commit, exp_commit);
      chk("stall", stall, !exp_commit);
      chk("halted", halted, exp_halted);
      chk("fault", fault, exp_fault);
      chk("fault_cause", fault_cause, exp_cause);
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("instret_cnt", instret_cnt, m_ret);
      if (!rst) begin
        m_cyc = 0;
        m_ret = 0;
      end else begin
        if (!exp_halted && !exp_fault) m_cyc = m_cyc + 1;
        if (exp_commit) m_ret = m_ret + 1;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic c, input logic h, input logic f,
                     input logic [1:0] fc);
    exp_commit = c;
    exp_halted = h;
    exp_fault  = f;
    exp_cause  = fc;
    @(negedge clk);
  endtask

  initial begin
    rst = 0; pc = 0; mem_addr = 0; re_mem = 0; we_mem = 0;
    halt_req = 0; wdata = 0; wmask = 0;
    imem.r_request_ready = 0; imem.r_reply_valid = 0;
    imem.r_reply_bits = 0; imem.w_request_ready = 0;
    imem.w_reply_valid = 0;
    dmem.r_request_ready = 0; dmem.r_reply_valid = 0;
    dmem.r_reply_bits = 0; dmem.w_request_ready = 0;
    dmem.w_reply_valid = 0;
    nxt();
    chk_en = 1;
    cyc(0, 0, 0, 0);
    chk("rst_ivalid", imem.r_request_valid, 0);
    chk("rst_inst", inst, 32'h13);

    // zero-wait ADDI from the upper slot
    nxt(); rst = 1;
    pc = 64'h4; imem.r_request_ready = 1; imem.r_reply_valid = 1;
    imem.r_reply_bits = 64'h00500093_DEADBEEF;
    cyc(0, 0, 0, 0);
    chk("if_valid", imem.r_request_valid, 1);
    chk("if_raddr", imem.r_request_bits, 64'h4);
    nxt(); cyc(0, 0, 0, 0);
    chk("if_rready", imem.r_reply_ready, 1);
    nxt(); cyc(1, 0, 0, 0);
    chk("inst_hi", inst, 32'h00500093);
    nxt(); imem.r_request_ready = 0; cyc(0, 0, 0, 0);
    chk("addi_cyc", cycle_cnt, 3);
    chk("addi_ret", instret_cnt, 1);

    // store with write-request ready held off 5 cycles
    nxt(); pc = 64'h8; imem.r_request_ready = 1;
    imem.r_reply_bits = 64'hFFFFFFFF_00112023;
    cyc(0, 0, 0, 0);
    nxt(); cyc(0, 0, 0, 0);
    nxt(); we_mem = 1; mem_addr = 64'h1000;
    wdata = 64'h11223344_55667788; wmask = 8'h0F;
    chk("inst_lo", inst, 32'h00112023);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) nxt();
      dmem.w_request_ready = (i == 5);
      cyc(0, 0, 0, 0);
      chk("st_wvalid", dmem.w_request_valid, 1);
      chk("st_rvalid", dmem.r_request_valid, 0);
      chk("st_waddr", dmem.w_request_bits.waddr, 64'h1000);
      chk("st_wdata", dmem.w_request_bits.wdata, 64'h11223344_55667788);
      chk("st_wmask", dmem.w_request_bits.wmask, 8'h0F);
    end
    nxt(); dmem.w_request_ready = 0; cyc(0, 0, 0, 0);
    chk("st_wready", dmem.w_reply_ready, 1);
    chk("st_rready", dmem.r_reply_ready, 0);
    chk("st_held", dmem.w_request_valid, 0);
    nxt(); dmem.w_reply_valid = 1; cyc(1, 0, 0, 0);

    // simultaneous load and store
    nxt(); dmem.w_reply_valid = 0; we_mem = 0; pc = 64'hC;
    cyc(0, 0, 0, 0);
    nxt(); cyc(0, 0, 0, 0);
    nxt(); re_mem = 1; we_mem = 1;
    dmem.r_request_ready = 1; dmem.w_request_ready = 1;
    cyc(0, 0, 0, 0);
    chk("ldst_rvalid", dmem.r_request_valid, 0);
    chk("ldst_wvalid", dmem.w_request_valid, 0);
    nxt(); cyc(0, 0, 1, 3);
    chk("ldst_cause", fault_cause, 3);
    chk("ldst_cyc", cycle_cnt, 17);
    chk("ldst_ret", instret_cnt, 2);
    nxt(); re_mem = 0; we_mem = 0;
    dmem.r_request_ready = 0; dmem.w_request_ready = 0;
    cyc(0, 0, 1, 3);
    chk("fault_ivalid", imem.r_request_valid, 0);
    nxt(); rst = 0; cyc(0, 0, 1, 3);

    // fetch reply never arrives: timeout after 8 waits
    nxt(); rst = 1; pc = 64'h10; imem.r_reply_valid = 0;
    cyc(0, 0, 0, 0);
    chk("rst_nop", inst, 32'h13);
    for (int i = 0; i < 8; i++) begin
      nxt(); cyc(0, 0, 0, 0);
    end
    nxt(); cyc(0, 0, 1, 1);
    chk("to_cause", fault_cause, 1);
    chk("to_cyc", cycle_cnt, 9);
    nxt(); cyc(0, 0, 1, 1);
    chk("to_frozen", cycle_cnt, 9);
    nxt(); rst = 0; cyc(0, 0, 1, 1);

    // halt requested mid-fetch
    nxt(); rst = 1; pc = 64'h14; imem.r_reply_valid = 1;
    imem.r_reply_bits = 64'h00000013_00000013;
    cyc(0, 0, 0, 0);
    chk("post_to_ivalid", imem.r_request_valid, 1);
    chk("post_to_inst", inst, 32'h13);
    nxt(); halt_req = 1; cyc(0, 0, 0, 0);
    nxt(); cyc(1, 0, 0, 0);
    nxt(); cyc(0, 1, 0, 0);
    chk("halt_ivalid", imem.r_request_valid, 0);
    nxt(); halt_req = 0; cyc(0, 1, 0, 0);
    chk("halt_cyc", cycle_cnt, 3);
    nxt(); pc = 64'h18; cyc(0, 0, 0, 0);
    chk("unhalt_ivalid", imem.r_request_valid, 1);

    // reset while a load reply is pending
    nxt(); cyc(0, 0, 0, 0);
    nxt(); re_mem = 1; mem_addr = 64'h2000; dmem.r_request_ready = 1;
    cyc(0, 0, 0, 0);
    chk("ld_rvalid", dmem.r_request_valid, 1);
    chk("ld_raddr", dmem.r_request_bits, 64'h2000);
    nxt(); rst = 0; dmem.r_reply_valid = 1; cyc(0, 0, 0, 0);
    chk("rstmem_rready", dmem.r_reply_ready, 0);
    chk("rstmem_wready", dmem.w_reply_ready, 0);
    chk("rstmem_ivalid", imem.r_request_valid, 0);
    chk("rstmem_dvalid", dmem.r_request_valid, 0);

    // zero-wait load commits in its fourth cycle
    nxt(); rst = 1; dmem.r_reply_valid = 0; re_mem = 0;
    cyc(0, 0, 0, 0);
    chk("rstmem_cyc", cycle_cnt, 0);
    chk("rstmem_if", imem.r_request_valid, 1);
    nxt(); cyc(0, 0, 0, 0);
    nxt(); re_mem = 1; cyc(0, 0, 0, 0);
    nxt(); dmem.r_reply_valid = 1; cyc(1, 0, 0, 0);
    chk("ld_rready", dmem.r_reply_ready, 1);
    chk("ld_wready", dmem.w_reply_ready, 0);
    nxt(); dmem.r_reply_valid = 0; re_mem = 0;
    imem.r_request_ready = 0; cyc(0, 0, 0, 0);
    chk("ld_cyc", cycle_cnt, 4);
    chk("ld_ret", instret_cnt, 1);

    nxt();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
